// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter and sequencer in front of a single-port synchronous
//   memory. One transaction is accepted per cycle using sticky round-robin
//   with a burst cap. The winning command is registered onto the memory port,
//   and a small tag travels alongside it so that read data and out-of-range
//   errors can be steered back to the right requester two cycles later.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_x, we_x           request (held until granted), write/read select
//   addr_x, wdata_x       word address and write data per requester
//   gnt_x                 combinational grant; accept = req_x & gnt_x
//   rvalid_x, err_x       one-cycle read-valid / out-of-range strobes
//   rdata                 shared read data, straight from mem_dout
//   mem_we, mem_addr,     registered memory command
//   mem_din
//   mem_dout              registered read data from the memory array

module mem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 26,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic              err_0,
    output logic              err_1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);
    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_e;

    owner_e             owner_q,    owner_d;
    logic [CNT_W-1:0]   burst_q,    burst_d;
    logic               mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_din_q,  mem_din_d;
    // Tag layout: {valid, is_read, requester}
    logic [2:0]         tag_q,      tag_d;
    logic [1:0]         rvalid_q,   rvalid_d;
    logic [1:0]         err_q,      err_d;

    logic               grant_0, grant_1;
    logic               accept;
    logic               sel;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_in_range;
    logic               issued_in_range;

    // Grant decision. Under contention the owner keeps the port until it has
    // used up its burst allowance; a lone requester always wins, which is also
    // how an owner that drops its request hands over in the same cycle.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (rst_n) begin
            if (req_0 && req_1) begin
                if (burst_q < MAX_CNT) begin
                    grant_0 = (owner_q == OWNER_0);
                    grant_1 = (owner_q == OWNER_1);
                end else begin
                    grant_0 = (owner_q == OWNER_1);
                    grant_1 = (owner_q == OWNER_0);
                end
            end else begin
                grant_0 = req_0;
                grant_1 = req_1;
            end
        end
    end

    // Mux the winning requester's command; grants imply requests, so a grant
    // alone means the transaction is accepted on the coming edge.
    always_comb begin
        accept       = grant_0 | grant_1;
        sel          = grant_1;
        sel_we       = sel ? we_1    : we_0;
        sel_addr     = sel ? addr_1  : addr_0;
        sel_wdata    = sel ? wdata_1 : wdata_0;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_L);
    end

    // Next-state for arbitration bookkeeping, the issue stage and the
    // response stage. The response stage checks the range of the address
    // actually issued, which mem_addr_q still holds while the tag is valid.
    always_comb begin
        owner_d    = owner_q;
        burst_d    = burst_q;
        if (accept) begin
            if (owner_e'(sel) == owner_q) begin
                burst_d = (burst_q == MAX_CNT) ? burst_q : burst_q + CNT_W'(1);
            end else begin
                owner_d = owner_e'(sel);
                burst_d = CNT_W'(1);
            end
        end

        mem_we_d   = accept & sel_we & sel_in_range;
        mem_addr_d = accept ? sel_addr  : mem_addr_q;
        mem_din_d  = accept ? sel_wdata : mem_din_q;
        tag_d      = {accept, ~sel_we, sel};

        issued_in_range = ({1'b0, mem_addr_q} < DEPTH_L);
        rvalid_d = 2'b00;
        err_d    = 2'b00;
        if (tag_q[2]) begin
            if (!issued_in_range) begin
                err_d[tag_q[0]] = 1'b1;
            end else if (tag_q[1]) begin
                rvalid_d[tag_q[0]] = 1'b1;
            end
        end
    end

    // State registers. Reset clears the tag and the response strobes, so a
    // transaction in flight when reset arrives never produces a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= OWNER_0;
            burst_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tag_q      <= 3'b000;
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            tag_q      <= tag_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign gnt_0    = grant_0;
    assign gnt_1    = grant_1;
    assign rvalid_0 = rvalid_q[0];
    assign rvalid_1 = rvalid_q[1];
    assign err_0    = err_q[0];
    assign err_1    = err_q[1];
    assign rdata    = mem_dout;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: a behavioural single-port memory, a table of
//   arbitration vectors, hand-written multi-cycle sequences and a randomized
//   phase checked against a transaction-level reference model. A second
//   instance with MAX_BURST = 1 is used for the strict-alternation case.

module tb_mem_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 26;
    localparam int MAXB  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_0, req_1, we_0, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1;
    logic [DW-1:0] rdata, mem_din, mem_dout;
    logic          mem_we;
    logic [AW-1:0] mem_addr;

    logic          b1_gnt_0, b1_gnt_1, b1_rv_0, b1_rv_1, b1_err_0, b1_err_1, b1_we;
    logic [DW-1:0] b1_rdata, b1_din;
    logic [AW-1:0] b1_addr;
    logic [DW-1:0] zero_word = '0;

    logic          seed_mem;
    logic [DW-1:0] mem_arr [32];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .err_0(err_0), .err_1(err_1), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(b1_gnt_0), .gnt_1(b1_gnt_1), .rvalid_0(b1_rv_0), .rvalid_1(b1_rv_1),
        .err_0(b1_err_0), .err_1(b1_err_1), .rdata(b1_rdata),
        .mem_we(b1_we), .mem_addr(b1_addr), .mem_din(b1_din), .mem_dout(zero_word)
    );

    // Behavioural single-port memory: registered read, no read on write cycles.
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= 32'hA500_0000 + 32'(i);
        end else if (mem_we) begin
            mem_arr[mem_addr] <= mem_din;
        end else begin
            mem_dout <= mem_arr[mem_addr];
        end
    end

    // Reference model: transaction-level view of owner, burst count, the
    // memory contents and the responses expected in future cycles.
    typedef struct {
        int          due;
        bit          is_err;
        int          who;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    resp_t       resp_q[$];
    wr_t         wr_q[$];
    logic [31:0] shadow [32];
    int          m_owner, m_cnt, cyc, last_win;
    int          n_compared, n_mismatched;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic r0, input logic w0,
                                 input logic [4:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1,
                                 input logic [4:0] a1, input logic [31:0] d1);
        rst_n = rst;
        req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
        req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // Compare this cycle's outputs with the model (or the table's grant),
    // then advance the model across the coming edge.
    task automatic checkOutput(input bit use_table, input bit eg0, input bit eg1);
        int          winner;
        bit          erv [2];
        bit          eer [2];
        logic [31:0] edat [2];
        bit          ewe;
        logic [4:0]  ewa, a;
        logic [31:0] ewd, d;
        bit          w;
        @(negedge clk);
        winner = -1;
        if (rst_n) begin
            if (req_0 && req_1) winner = (m_cnt < MAXB) ? m_owner : 1 - m_owner;
            else if (req_0)     winner = 0;
            else if (req_1)     winner = 1;
        end
        checkVal("gnt_0", gnt_0, use_table ? eg0 : (winner == 0));
        checkVal("gnt_1", gnt_1, use_table ? eg1 : (winner == 1));

        erv[0] = 0; erv[1] = 0; eer[0] = 0; eer[1] = 0; edat[0] = '0; edat[1] = '0;
        foreach (resp_q[j]) begin
            if (resp_q[j].due == cyc) begin
                if (resp_q[j].is_err) eer[resp_q[j].who] = 1;
                else begin
                    erv[resp_q[j].who]  = 1;
                    edat[resp_q[j].who] = resp_q[j].data;
                end
            end
        end
        checkVal("rvalid_0", rvalid_0, erv[0]);
        checkVal("rvalid_1", rvalid_1, erv[1]);
        checkVal("err_0", err_0, eer[0]);
        checkVal("err_1", err_1, eer[1]);
        if (erv[0]) checkVal("rdata_0", rdata, edat[0]);
        if (erv[1]) checkVal("rdata_1", rdata, edat[1]);

        ewe = 0; ewa = '0; ewd = '0;
        foreach (wr_q[j]) begin
            if (wr_q[j].due == cyc) begin
                ewe = 1; ewa = wr_q[j].addr; ewd = wr_q[j].data;
            end
        end
        checkVal("mem_we", mem_we, ewe);
        if (ewe) begin
            checkVal("mem_addr", mem_addr, ewa);
            checkVal("mem_din", mem_din, ewd);
        end

        if (!rst_n) begin
            m_owner = 0;
            m_cnt   = 0;
            resp_q.delete();
            wr_q.delete();
        end else begin
            if (winner >= 0) begin
                if (winner == m_owner) begin
                    if (m_cnt < MAXB) m_cnt++;
                end else begin
                    m_owner = winner;
                    m_cnt   = 1;
                end
                a = (winner == 0) ? addr_0 : addr_1;
                d = (winner == 0) ? wdata_0 : wdata_1;
                w = (winner == 0) ? we_0 : we_1;
                if (int'(a) >= DEPTH) begin
                    resp_q.push_back('{due: cyc + 2, is_err: 1'b1, who: winner, data: 32'd0});
                end else if (w) begin
                    shadow[a] = d;
                    wr_q.push_back('{due: cyc + 1, addr: a, data: d});
                end else begin
                    resp_q.push_back('{due: cyc + 2, is_err: 1'b0, who: winner, data: shadow[a]});
                end
            end
            begin
                resp_t keep_r[$];
                wr_t   keep_w[$];
                foreach (resp_q[j]) if (resp_q[j].due > cyc) keep_r.push_back(resp_q[j]);
                foreach (wr_q[j])   if (wr_q[j].due > cyc)   keep_w.push_back(wr_q[j]);
                resp_q = keep_r;
                wr_q   = keep_w;
            end
        end
        last_win = winner;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst;
        bit r0;
        bit r1;
        bit eg0;
        bit eg1;
    } vec_t;

    vec_t tbl [19];

    bit          pr [2];
    bit          pw [2];
    logic [4:0]  pa [2];
    logic [31:0] pd [2];

    initial begin
        // Reset, contention with MAX_BURST = 4, owner drop and burst restart.
        tbl = '{
            '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,1,0,0},
            '{1,1,1,1,0}, '{1,1,1,1,0}, '{1,1,1,1,0}, '{1,1,1,1,0},
            '{1,1,1,0,1}, '{1,1,1,0,1}, '{1,1,1,0,1}, '{1,1,1,0,1},
            '{1,1,1,1,0},
            '{1,1,1,1,0},
            '{1,0,1,0,1},
            '{1,1,1,0,1}, '{1,1,1,0,1}, '{1,1,1,0,1},
            '{1,1,1,1,0},
            '{1,0,0,0,0}
        };
        n_compared = 0; n_mismatched = 0;
        m_owner = 0; m_cnt = 0; cyc = 0; last_win = -1;
        for (int i = 0; i < 32; i++) shadow[i] = 32'hA500_0000 + 32'(i);

        seed_mem = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        seed_mem = 1'b0;
        cyc = 1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].r0, 1'b0, 5'd5, 32'd0, tbl[i].r1, 1'b0, 5'd7, 32'd0);
            #1;
            if (i == 2) begin
                checkVal("rst_mem_addr", mem_addr, 32'd0);
                checkVal("rst_mem_din", mem_din, 32'd0);
                checkVal("rst_b1_gnt_0", b1_gnt_0, 32'd0);
            end
            if (i >= 3 && i <= 11) begin
                checkVal("b1_gnt_0", b1_gnt_0, ((i - 3) % 2 == 0) ? 32'd1 : 32'd0);
                checkVal("b1_gnt_1", b1_gnt_1, ((i - 3) % 2 == 1) ? 32'd1 : 32'd0);
            end
            checkOutput(1'b1, tbl[i].eg0, tbl[i].eg1);
        end

        // Write then read back the same address on consecutive cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkVal("wr_mem_we", mem_we, 32'd1);
        checkVal("wr_mem_addr", mem_addr, 32'd3);
        checkVal("wr_mem_din", mem_din, 32'hDEADBEEF);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("rd_rvalid_0", rvalid_0, 32'd1);
        checkVal("rd_rdata", rdata, 32'hDEADBEEF);
        checkOutput(1'b0, 1'b0, 1'b0);

        // Out-of-range write and read on address 26.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd26, 32'h12345678);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("oor_wr_mem_we", mem_we, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("oor_wr_err_1", err_1, 32'd1);
        checkVal("oor_wr_rvalid_1", rvalid_1, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd26, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("oor_rd_err_1", err_1, 32'd1);
        checkVal("oor_rd_rvalid_1", rvalid_1, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);

        // Highest valid address.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd25, 32'h12345678);
        checkOutput(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd25, 32'd0);
        checkVal("a25_mem_we", mem_we, 32'd1);
        checkVal("a25_mem_addr", mem_addr, 32'd25);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("a25_rvalid_1", rvalid_1, 32'd1);
        checkVal("a25_rdata", rdata, 32'h12345678);
        checkOutput(1'b0, 1'b0, 1'b0);

        // Reset while a read is in flight drops its response.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("mid_rst_rvalid_0", rvalid_0, 32'd0);
        checkVal("mid_rst_err_0", err_0, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);
        idleStimulus();
        checkVal("mid_rst_rvalid_0_late", rvalid_0, 32'd0);
        checkOutput(1'b0, 1'b0, 1'b0);

        // Randomized traffic; requests stay put until the model says accepted.
        for (int k = 0; k < 2; k++) begin
            pr[k] = 0; pw[k] = 0; pa[k] = '0; pd[k] = '0;
        end
        last_win = -1;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pr[k] || last_win == k) begin
                    pr[k] = ($urandom_range(0, 3) != 0);
                    pw[k] = ($urandom_range(0, 1) == 1);
                    pa[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(26, 31))
                                                         : 5'($urandom_range(0, 25));
                    pd[k] = $urandom;
                end
            end
            applyStimulus(($urandom_range(0, 63) != 0), pr[0], pw[0], pa[0], pd[0],
                          pr[1], pw[1], pa[1], pd[1]);
            checkOutput(1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            idleStimulus();
            checkOutput(1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
